// File: rtl/paddle_ctrl.sv
// paddle_ctrl: button-driven vertical paddle with synchronizers, debouncers, per-frame motion and pixel colouring
module paddle_ctrl #(
  parameter int          PADDLE_X  = 32,
  parameter int          PADDLE_W  = 10,
  parameter int          PADDLE_H  = 72,
  parameter int          STEP      = 4,
  parameter int          SCREEN_H  = 480,
  parameter int          DB_CYCLES = 250000,
  parameter logic [11:0] COLOR     = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       video_on,
  input  logic       p_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] paddle_x,
  output logic [9:0] paddle_y,
  output logic [9:0] paddle_height,
  output logic       paddle_on,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);
  localparam int Y_MAX = SCREEN_H - PADDLE_H;
  localparam int Y_RST = Y_MAX / 2;
  localparam int CW    = $clog2(DB_CYCLES + 1);

  logic [1:0]    r_up_s, r_dn_s;
  logic [1:0]    w_sync;
  logic [1:0]    r_db;
  logic          r_frame_tick;
  logic [9:0]    r_y;
  logic [10:0]   w_sub, w_add;
  logic [9:0]    w_up_y, w_dn_y, w_next_y;
  logic          w_on;
  logic [11:0]   w_rgb;

  // two-flop synchronizers for the raw buttons
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_up_s <= '0;
      r_dn_s <= '0;
    end else begin
      r_up_s <= {r_up_s[0], btn_up};
      r_dn_s <= {r_dn_s[0], btn_down};
    end

  assign w_sync = {r_dn_s[1], r_up_s[1]};

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [CW-1:0] r_cnt;
    // flip the debounced state after DB_CYCLES consecutive mismatching cycles
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_cnt   <= '0;
        r_db[i] <= 1'b0;
      end else if (w_sync[i] == r_db[i]) begin
        r_cnt   <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_db[i] <= ~r_db[i];
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
  end

  // one pulse per frame, at the first pixel of the first blanking line
  always_ff @(posedge clk or posedge rst)
    if (rst) r_frame_tick <= 1'b0;
    else     r_frame_tick <= p_tick && pixel_x == 10'd0 && pixel_y == 10'(SCREEN_H);

  // clamped candidate positions, computed one bit wider to catch under/overflow
  always_comb begin
    w_sub    = {1'b0, r_y} - 11'(STEP);
    w_add    = {1'b0, r_y} + 11'(STEP);
    w_up_y   = w_sub[10] ? 10'd0 : w_sub[9:0];
    w_dn_y   = (w_add > 11'(Y_MAX)) ? 10'(Y_MAX) : w_add[9:0];
    w_next_y = (r_db == 2'b01) ? w_up_y : (r_db == 2'b10) ? w_dn_y : r_y;
  end

  // paddle position moves only on the cycle after the frame tick
  always_ff @(posedge clk or posedge rst)
    if (rst)               r_y <= 10'(Y_RST);
    else if (r_frame_tick) r_y <= w_next_y;

  // pixel hit test and colour selection
  always_comb begin
    w_on  = pixel_x >= 10'(PADDLE_X) && {1'b0, pixel_x} < 11'(PADDLE_X + PADDLE_W) &&
            pixel_y >= r_y && {1'b0, pixel_y} < {1'b0, r_y} + 11'(PADDLE_H);
    w_rgb = (video_on && w_on) ? COLOR : 12'h000;
  end

  assign paddle_x      = 10'(PADDLE_X);
  assign paddle_y      = r_y;
  assign paddle_height = 10'(PADDLE_H);
  assign paddle_on     = w_on;
  assign r             = w_rgb[11:8];
  assign g             = w_rgb[7:4];
  assign b             = w_rgb[3:0];
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed vector table plus hand-written multi-cycle sequences for paddle_ctrl
module tb_paddle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       video_on = 1'b0;
  logic       p_tick = 1'b0;
  logic [9:0] pixel_x = 10'd100;
  logic [9:0] pixel_y = 10'd100;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [9:0] paddle_x, paddle_y, paddle_height;
  logic       paddle_on;
  logic [3:0] r, g, b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        vo;
    logic        on;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[8];

  paddle_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .p_tick(p_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_height(paddle_height),
    .paddle_on(paddle_on), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      @(negedge clk);
      p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
      @(negedge clk);
      p_tick = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{10'd32, 10'd204, 1'b1, 1'b1, 12'hFFF};
    tbl[1] = '{10'd41, 10'd275, 1'b1, 1'b1, 12'hFFF};
    tbl[2] = '{10'd42, 10'd204, 1'b1, 1'b0, 12'h000};
    tbl[3] = '{10'd32, 10'd276, 1'b1, 1'b0, 12'h000};
    tbl[4] = '{10'd31, 10'd240, 1'b1, 1'b0, 12'h000};
    tbl[5] = '{10'd36, 10'd203, 1'b1, 1'b0, 12'h000};
    tbl[6] = '{10'd32, 10'd204, 1'b0, 1'b1, 12'h000};
    tbl[7] = '{10'd37, 10'd240, 1'b1, 1'b1, 12'hFFF};

    wait_clk(3);
    chk("reset_y", paddle_y, 204);
    chk("reset_x", paddle_x, 32);
    chk("reset_h", paddle_height, 72);
    chk("reset_rgb", {r, g, b}, 0);
    rst = 1'b0;
    wait_clk(2);

    for (int i = 0; i < 8; i++) begin
      pixel_x = tbl[i].px; pixel_y = tbl[i].py; video_on = tbl[i].vo;
      #1;
      chk($sformatf("scan_on[%0d]", i), paddle_on, tbl[i].on);
      chk($sformatf("scan_rgb[%0d]", i), {r, g, b}, tbl[i].rgb);
    end
    video_on = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;

    @(negedge clk); btn_up = 1'b1;
    wait_clk(3); btn_up = 1'b0;
    wait_clk(10);
    frame(3);
    chk("glitch_hold", paddle_y, 204);

    @(negedge clk); p_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd480;
    btn_up = 1'b1;
    wait_clk(10);
    pixel_x = 10'd100; pixel_y = 10'd100;
    chk("no_ptick_hold", paddle_y, 204);

    @(negedge clk); p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    @(negedge clk); p_tick = 1'b0; pixel_x = 10'd100; pixel_y = 10'd100;
    chk("tick_cycle_unchanged", paddle_y, 204);
    @(negedge clk);
    chk("up_first_step", paddle_y, 200);
    wait_clk(2);
    chk("once_per_frame", paddle_y, 200);
    frame(49);
    chk("up_before_zero", paddle_y, 4);
    frame(1);
    chk("up_reach_zero", paddle_y, 0);
    frame(9);
    chk("up_no_wrap", paddle_y, 0);
    btn_up = 1'b0;

    @(negedge clk); rst = 1'b1; #1;
    chk("reset_again", paddle_y, 204);
    @(negedge clk); rst = 1'b0;
    btn_down = 1'b1;
    wait_clk(10);
    frame(1);
    chk("down_first_step", paddle_y, 208);
    frame(23);
    chk("down_to_300", paddle_y, 300);

    btn_up = 1'b1;
    wait_clk(10);
    frame(3);
    chk("both_hold", paddle_y, 300);
    btn_up = 1'b0;
    wait_clk(10);
    btn_down = 1'b0;
    wait_clk(10);
    frame(2);
    chk("neither_hold", paddle_y, 300);

    btn_down = 1'b1;
    wait_clk(10);
    frame(1);
    chk("down_resume", paddle_y, 304);
    frame(1);
    chk("down_at_308", paddle_y, 308);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("async_reset_mid", paddle_y, 204);
    @(negedge clk); rst = 1'b0;
    frame(1);
    chk("no_move_before_redebounce", paddle_y, 204);
    wait_clk(10);
    frame(1);
    chk("move_after_redebounce", paddle_y, 208);
    frame(49);
    chk("down_reach_max", paddle_y, 404);
    frame(1);
    chk("down_max", paddle_y, 408);
    frame(10);
    chk("down_clamp", paddle_y, 408);
    btn_down = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  PADDLE_X, 32, fixed left x of paddle;
  PADDLE_W, 10, paddle width in pixels;
  PADDLE_H, 72, paddle height in pixels;
  STEP, 4, pixels moved per frame;
  SCREEN_H, 480, visible lines;
  DB_CYCLES, 250000, debounce stability count in clk cycles;
  COLOR, 12'hFFF, paddle RGB.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, system clock;
  rst, in, 1, asynchronous reset, active-high;
  video_on, in, 1, visible-area flag from sync generator;
  p_tick, in, 1, pixel-rate enable;
  pixel_x, in, 10, current pixel column;
  pixel_y, in, 10, current pixel row;
  btn_up, in, 1, raw asynchronous up button, active-high;
  btn_down, in, 1, raw asynchronous down button, active-high;
  paddle_x, out, 10, paddle left edge, feeds ball stage;
  paddle_y, out, 10, paddle top edge, feeds ball stage;
  paddle_height, out, 10, paddle height, feeds ball stage;
  paddle_on, out, 1, current pixel inside paddle;
  r, g, b, out, 4 each, paddle colour output.
REQ-003 One clock (clk); reset is asynchronous and active-high (rst); no other clock or reset.

Function
REQ-004 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-005 Each synchronized button SHALL have an independent debouncer: a counter that clears whenever synced input equals the debounced state; the debounced state SHALL flip when the counter reaches DB_CYCLES consecutive mismatching cycles, and the counter SHALL then clear.
REQ-006 frame_tick SHALL be an internal one-clk pulse asserted when p_tick=1, pixel_x=0 and pixel_y=SCREEN_H; exactly one per frame.
REQ-007 On frame_tick with debounced up=1 and down=0: paddle_y <= max(0, paddle_y-STEP), computed at 11 bits, no underflow wrap.
REQ-008 On frame_tick with down=1 and up=0: paddle_y <= min(SCREEN_H-PADDLE_H, paddle_y+STEP).
REQ-009 Both or neither debounced button active, or no frame_tick: paddle_y SHALL hold.
REQ-010 paddle_y SHALL change at most once per frame, and only in the clk cycle after frame_tick, so it is stable throughout the visible area.
REQ-011 paddle_x SHALL be constant PADDLE_X; paddle_height SHALL be constant PADDLE_H.
REQ-012 paddle_on SHALL be combinational: PADDLE_X <= pixel_x < PADDLE_X+PADDLE_W and paddle_y <= pixel_y < paddle_y+PADDLE_H.
REQ-013 {r,g,b} SHALL be combinational and fully assigned on every path (no latches): 12'h000 when video_on=0; COLOR when paddle_on=1; otherwise 12'h000.
REQ-014 paddle_y SHALL never leave [0, SCREEN_H-PADDLE_H] under any input sequence.

Reset
REQ-015 While rst=1, independent of clk:
  paddle_y = (SCREEN_H-PADDLE_H)/2 = 204;
  synchronizer flops, debounced states and debounce counters = 0;
  frame_tick = 0.
REQ-016 Reset asserted mid-debounce or mid-move SHALL discard all pending state; operation resumes on the first clk edge after rst deasserts.

Verification (DB_CYCLES=4 for simulation)
REQ-017 Pulse rst -> paddle_y=204, paddle_x=32, paddle_height=72, r/g/b=0 with video_on=0.
REQ-018 Hold btn_up for 60 frames -> paddle_y decreases by 4 per frame to exactly 0 after 51 frames, then stays at 0 with no wrap.
REQ-019 Hold btn_down from 204 for 60 frames -> paddle_y reaches 408 and holds; both buttons held -> no change.
REQ-020 btn_up glitch high for 3 clk (below DB_CYCLES), then low -> debounced state never changes; paddle_y stays 204 across frames.
REQ-021 Assert rst while btn_down is debounced and paddle_y=300 -> paddle_y returns to 204 immediately; movement resumes only after re-debounce.
REQ-022 Scan with paddle_y=204 and video_on=1:
  pixel (32,204) and pixel (41,275) -> paddle_on=1, rgb=12'hFFF;
  pixel (42,204) and pixel (32,276) -> paddle_on=0, rgb=0.
